cnn_dispatch_control: RTL and testbench

Multi-bank dispatcher between the camera preprocessing frame buffers and the LeNet inference engine. It tracks NUM_BANKS independent "frame ready" levels and selects a pending bank round-robin when the engine is idle. It then issues a one-clock lenet_go pulse tagged with the bank index and follows the engine's ready/busy handshake to completion, releasing the bank afterwards. It adds dropped-frame accounting and a watchdog timeout for a hung engine.

---
 rtl/cnn_ctrl_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/cnn_dispatch_control.sv | 173 +++++++++++++++++
 tb/tb_cnn_dispatch_control.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Purpose : shared state encodings and helpers for the CNN frame dispatcher.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
package cnn_ctrl_pkg;

  // Per-bank frame lifecycle.
  typedef enum logic [1:0] {
    B_IDLE    = 2'd0,  // no frame in this bank
    B_PEND    = 2'd1,  // frame ready, waiting for the engine
    B_BUSY    = 2'd2,  // frame handed to the engine
    B_WAITLOW = 2'd3   // finished, waiting for the ready level to drop
  } bank_state_t;

  // Engine handshake tracker.
  typedef enum logic [1:0] {
    ENG_READY   = 2'd0,  // engine idle, may dispatch
    ENG_ACK     = 2'd1,  // go issued, waiting for engine to go busy
    ENG_RUN     = 2'd2,  // engine running, waiting for it to go idle
    ENG_RECOVER = 2'd3   // watchdog fired, waiting for engine to come back
  } eng_state_t;

  // Width of an index into n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : combinational round-robin pick among N requesters, search starts at ptr+1.
// Latency : zero (purely combinational).
// Backpressure: none; caller decides whether to accept the grant and move ptr.
// Ports   : req - request vector; ptr - last granted index;
//           grant_valid - any request present; grant_idx - chosen requester.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] cand;

  // Walk the offsets farthest-first so the nearest requester after ptr
  // is the last one written and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cnn_dispatch_control.sv
// Purpose : dispatches ready frame-buffer banks round-robin to the LeNet engine,
//           tracks the engine ready/busy handshake, counts dropped frames, and
//           aborts a hung inference with a watchdog.
// Latency : lenet_go one cycle after a bank is registered pending with engine idle;
//           bank_release one cycle after lenet_ready returns high.
// Backpressure: the engine's lenet_ready level gates dispatch; banks wait in
//           B_PEND while the engine is busy and are dropped if their level falls.
// Ports   : data_ready - per-bank frame level; lenet_ready - engine idle level;
//           lenet_go/go_bank - start pulse and bank tag; bank_release - per-bank
//           done/abort pulse; busy - inference in flight; timeout_err - watchdog
//           pulse; drop_cnt - saturating withdrawn-frame count.
module cnn_dispatch_control
  import cnn_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = idx_width(NUM_BANKS),
  parameter int TIMEOUT   = 1000000,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_BANKS-1:0] data_ready,
  input  logic                 lenet_ready,
  output logic                 lenet_go,
  output logic [BANK_W-1:0]    go_bank,
  output logic [NUM_BANKS-1:0] bank_release,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     drop_cnt
);

  // Watchdog counter only needs to reach TIMEOUT-1.
  localparam int              WD_W     = idx_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
  localparam int              SUM_W    = CNT_W + 1;

  bank_state_t            bank_q [NUM_BANKS];
  bank_state_t            bank_d [NUM_BANKS];
  eng_state_t             eng_q;
  eng_state_t             eng_d;
  logic [BANK_W-1:0]      rr_ptr;
  logic [WD_W-1:0]        wd_cnt;

  logic [NUM_BANKS-1:0]   pend_vec;
  logic [NUM_BANKS-1:0]   grant_vec;
  logic [NUM_BANKS-1:0]   rel_vec;
  logic [NUM_BANKS-1:0]   drop_vec;
  logic                   grant_vld;
  logic [BANK_W-1:0]      grant_idx;
  logic                   dispatch;
  logic                   complete;
  logic                   wd_hit;
  logic                   abort;
  logic [SUM_W-1:0]       drop_sum;
  logic [CNT_W-1:0]       drop_nxt;

  always_comb begin
    pend_vec = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      pend_vec[i] = (bank_q[i] == B_PEND);
    end
  end

  rr_arbiter #(
    .N  (NUM_BANKS),
    .IW (BANK_W)
  ) u_arb (
    .req         (pend_vec),
    .ptr         (rr_ptr),
    .grant_valid (grant_vld),
    .grant_idx   (grant_idx)
  );

  // Completion beats the watchdog when both land in the same cycle.
  always_comb begin
    dispatch = (eng_q == ENG_READY) && lenet_ready && grant_vld;
    complete = (eng_q == ENG_RUN) && lenet_ready;
    wd_hit   = (TIMEOUT != 0) && (wd_cnt == WD_LIMIT) &&
               ((eng_q == ENG_ACK) || (eng_q == ENG_RUN));
    abort    = wd_hit && !complete;
  end

  always_comb begin
    eng_d = eng_q;
    case (eng_q)
      ENG_READY:   if (dispatch) eng_d = ENG_ACK;
      ENG_ACK: begin
        if (wd_hit)            eng_d = ENG_RECOVER;
        else if (!lenet_ready) eng_d = ENG_RUN;
      end
      ENG_RUN: begin
        if (complete)    eng_d = ENG_READY;
        else if (wd_hit) eng_d = ENG_RECOVER;
      end
      ENG_RECOVER: if (lenet_ready) eng_d = ENG_READY;
      default:     eng_d = ENG_READY;
    endcase
  end

  // Per-bank next state. A bank granted in the cycle its level falls is
  // still dispatched, so the grant check precedes the drop check.
  always_comb begin
    grant_vec = '0;
    rel_vec   = '0;
    drop_vec  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      grant_vec[i] = dispatch && (grant_idx == BANK_W'(i));
      rel_vec[i]   = (complete || abort) && (go_bank == BANK_W'(i));
      bank_d[i]    = bank_q[i];
      case (bank_q[i])
        B_IDLE:    if (data_ready[i]) bank_d[i] = B_PEND;
        B_PEND: begin
          if (grant_vec[i]) begin
            bank_d[i] = B_BUSY;
          end else if (!data_ready[i]) begin
            bank_d[i]   = B_IDLE;
            drop_vec[i] = 1'b1;
          end
        end
        B_BUSY:    if (rel_vec[i]) bank_d[i] = data_ready[i] ? B_WAITLOW : B_IDLE;
        B_WAITLOW: if (!data_ready[i]) bank_d[i] = B_IDLE;
        default:   bank_d[i] = B_IDLE;
      endcase
    end
  end

  // Several banks may drop together; sum them one bit wider and clamp.
  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < NUM_BANKS; i++) begin
      drop_sum = drop_sum + SUM_W'(drop_vec[i]);
    end
    drop_nxt = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_q[i] <= B_IDLE;
      end
      eng_q        <= ENG_READY;
      rr_ptr       <= BANK_W'(NUM_BANKS - 1);
      wd_cnt       <= '0;
      lenet_go     <= 1'b0;
      go_bank      <= '0;
      bank_release <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_q[i] <= bank_d[i];
      end
      eng_q        <= eng_d;
      lenet_go     <= dispatch;
      bank_release <= rel_vec;
      timeout_err  <= abort;
      busy         <= (eng_d != ENG_READY);
      drop_cnt     <= drop_nxt;
      if (dispatch) begin
        go_bank <= grant_idx;
        rr_ptr  <= grant_idx;
      end
      // Counter stops mattering once the engine leaves ACK/RUN, so no clamp.
      if (dispatch) begin
        wd_cnt <= '0;
      end else if ((eng_q == ENG_ACK) || (eng_q == ENG_RUN)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnn_dispatch_control.sv
// Purpose : directed bench for cnn_dispatch_control with an event scoreboard.
// Latency : n/a.
// Backpressure: n/a.
module tb_cnn_dispatch_control;

  localparam int NB      = 2;
  localparam int TMO     = 100;
  localparam int CW      = 8;
  localparam int EV_GO   = 0;
  localparam int EV_TO   = 1;
  localparam int EV_REL  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] data_ready;
  logic          lenet_ready;
  logic          lenet_go;
  logic          go_bank;
  logic [NB-1:0] bank_release;
  logic          busy;
  logic          timeout_err;
  logic [CW-1:0] drop_cnt;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  logic prev_busy = 1'b0;

  cnn_dispatch_control #(
    .NUM_BANKS (NB),
    .TIMEOUT   (TMO),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_ready   (data_ready),
    .lenet_ready  (lenet_ready),
    .lenet_go     (lenet_go),
    .go_bank      (go_bank),
    .bank_release (bank_release),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input int val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic check_evt(input int kind, input int val);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, expected no event",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_err++;
        $display("FAIL event: got kind=%0d val=%0d cycle=%0d, expected kind=%0d val=%0d cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (lenet_go) begin
        check_evt(EV_GO, int'(go_bank));
        chk("go_while_busy", int'(prev_busy), 0);
      end
      if (timeout_err) check_evt(EV_TO, 0);
      if (bank_release != '0) check_evt(EV_REL, int'(bank_release));
      prev_busy = busy;
    end
  end

  // Engine goes busy now, returns idle after hold cycles; release follows next edge.
  task automatic handshake(input int hold, input int rel);
    lenet_ready = 1'b0;
    repeat (hold) @(negedge clk);
    lenet_ready = 1'b1;
    push(EV_REL, rel, cyc + 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_go"},      int'(lenet_go), 0);
    chk({tag, "_bank"},    int'(go_bank), 0);
    chk({tag, "_rel"},     int'(bank_release), 0);
    chk({tag, "_busy"},    int'(busy), 0);
    chk({tag, "_tmo"},     int'(timeout_err), 0);
    chk({tag, "_drop"},    int'(drop_cnt), 0);
  endtask

  initial begin
    int c0, c1, d0, e0, f0;
    rst_n       = 1'b0;
    data_ready  = '0;
    lenet_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single dispatch of bank 0 and normal completion after 50 busy cycles.
    c0 = cyc;
    data_ready = 2'b01;
    push(EV_GO, 0, c0 + 2);
    repeat (2) @(negedge clk);
    chk("busy_after_go", int'(busy), 1);
    @(negedge clk);
    handshake(50, 2'b01);
    @(negedge clk);
    chk("busy_after_release", int'(busy), 0);
    data_ready = 2'b00;
    @(negedge clk);

    // Both banks ready; pointer sits at 0, so order is bank1, bank0, bank1.
    c1 = cyc;
    data_ready = 2'b11;
    push(EV_GO, 1, c1 + 2);
    repeat (2) @(negedge clk);
    handshake(3, 2'b10);
    push(EV_GO, 0, c1 + 7);
    @(negedge clk);
    data_ready = 2'b01;
    @(negedge clk);
    data_ready = 2'b11;
    handshake(3, 2'b01);
    push(EV_GO, 1, c1 + 12);
    repeat (2) @(negedge clk);
    handshake(2, 2'b10);
    @(negedge clk);
    data_ready = 2'b00;
    repeat (2) @(negedge clk);

    // Drop while busy, then watchdog expiry with the engine stuck low.
    d0 = cyc;
    data_ready = 2'b01;
    push(EV_GO, 0, d0 + 2);
    repeat (2) @(negedge clk);
    lenet_ready = 1'b0;
    push(EV_TO, 0, d0 + 2 + TMO);
    push(EV_REL, 2'b01, d0 + 2 + TMO);
    @(negedge clk);
    data_ready = 2'b11;
    repeat (5) @(negedge clk);
    data_ready = 2'b01;
    @(negedge clk);
    chk("drop_one", int'(drop_cnt), 1);
    repeat (d0 + 2 + TMO - cyc) @(negedge clk);
    chk("busy_in_recover", int'(busy), 1);
    for (int i = 0; i < 300; i++) begin
      data_ready = 2'b11;
      @(negedge clk);
      data_ready = 2'b01;
      @(negedge clk);
      if (i == 9) chk("drop_eleven", int'(drop_cnt), 11);
    end
    chk("drop_saturated", int'(drop_cnt), 255);
    chk("busy_still_recover", int'(busy), 1);
    lenet_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("busy_after_recover", int'(busy), 0);
    data_ready = 2'b00;
    repeat (2) @(negedge clk);

    // Reset mid-run: outputs clear at once, no release for the abandoned frame.
    e0 = cyc;
    data_ready = 2'b01;
    push(EV_GO, 0, e0 + 2);
    repeat (2) @(negedge clk);
    lenet_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    lenet_ready = 1'b1;
    repeat (2) @(negedge clk);
    f0 = cyc;
    rst_n = 1'b1;
    push(EV_GO, 0, f0 + 2);
    repeat (2) @(negedge clk);
    handshake(4, 2'b01);
    repeat (3) @(negedge clk);

    chk("leftover_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
